// File: rtl/button_press_counter_pkg.sv
// button_press_counter_pkg
//   Shared definitions for the button press counter: the debounce FSM state
//   encoding. Test benches import this package to probe the FSM state.
package button_press_counter_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

endpackage

// File: rtl/btn_sync.sv
// btn_sync
//   Parameterized 2-flop synchronizer for asynchronous inputs entering the
//   clk domain. Both stages reset asynchronously to RESET_VAL.
// Ports
//   clk_i   in   1      destination clock
//   rst_ni  in   1      asynchronous active-low reset
//   d_i     in   WIDTH  asynchronous input
//   q_o     out  WIDTH  synchronized output (two clk edges of latency)
module btn_sync #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_press_counter.sv
// button_press_counter
//   Synchronizes and debounces an active-low, bouncy push button. Each
//   debounced press increments a wrapping LED count and emits a one-cycle
//   press_pulse.
//   Optional feature: define BTN_AUTOREPEAT_EN to repeat the count every
//   REPEAT_COUNT+1 cycles while the button stays held.
// Ports
//   clk          in   1          system clock (12 MHz)
//   rst_btn      in   1          asynchronous active-low reset
//   inc_btn      in   1          raw push button, active-low, asynchronous
//   led          out  LED_WIDTH  registered press count (wraps)
//   press_pulse  out  1          registered, high one cycle per counted press
module button_press_counter
  import button_press_counter_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned DEBOUNCE_COUNT = 120000 - 1,
  parameter int unsigned LED_WIDTH      = 4,
  parameter int unsigned REPEAT_COUNT   = 6000000 - 1
) (
  input  logic                 clk,
  input  logic                 rst_btn,
  input  logic                 inc_btn,
  output logic [LED_WIDTH-1:0] led,
  output logic                 press_pulse
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT_EN = 1'b1;
`else
  localparam bit AUTOREPEAT_EN = 1'b0;
`endif

  localparam logic [COUNT_WIDTH-1:0] DEB_LAST = COUNT_WIDTH'(DEBOUNCE_COUNT);
  localparam logic [COUNT_WIDTH-1:0] RPT_LAST = COUNT_WIDTH'(REPEAT_COUNT);

  logic btn_sync_n;
  logic pressed;

  btn_state_t             state_q, state_d;
  logic [COUNT_WIDTH-1:0] timer_q, timer_d;
  logic [LED_WIDTH-1:0]   led_q,   led_d;
  logic                   pulse_q, pulse_d;

  // Synchronizer idles at 1 so reset reads as "released".
  btn_sync #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_btn),
    .d_i    (inc_btn),
    .q_o    (btn_sync_n)
  );

  assign pressed = ~btn_sync_n;

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= IDLE;
      timer_q <= '0;
      led_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
    end
  end

  // Timer returns to 0 on every state change; it only counts while waiting
  // for stability (or, with auto-repeat, while held in PRESSED).
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    led_d   = led_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (pressed) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = PRESSED;
          timer_d = '0;
          led_d   = led_q + LED_WIDTH'(1);
          pulse_d = 1'b1;
        end else begin
          timer_d = timer_q + COUNT_WIDTH'(1);
        end
      end
      PRESSED: begin
        timer_d = '0;
        if (!pressed) begin
          state_d = RELEASE_WAIT;
        end else if (AUTOREPEAT_EN) begin
          if (timer_q == RPT_LAST) begin
            led_d   = led_q + LED_WIDTH'(1);
            pulse_d = 1'b1;
          end else begin
            timer_d = timer_q + COUNT_WIDTH'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (pressed) begin
          state_d = PRESSED;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign led         = led_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_press_counter.sv
module tb_button_press_counter;
  import button_press_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_btn;
  logic       inc_btn;
  logic [3:0] led;
  logic       press_pulse;

  always #5 clk = ~clk;

  button_press_counter #(
    .COUNT_WIDTH    (8),
    .DEBOUNCE_COUNT (9),
    .LED_WIDTH      (4),
    .REPEAT_COUNT   (19)
  ) dut (
    .clk         (clk),
    .rst_btn     (rst_btn),
    .inc_btn     (inc_btn),
    .led         (led),
    .press_pulse (press_pulse)
  );

  // Edge counter: at a negedge it equals the number of posedges so far.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int unsigned pulse_cnt   = 0;
  int unsigned last_pulse  = 0;
  int unsigned wide_pulses = 0;
  logic        prev_pulse  = 1'b0;
  int unsigned pulse_log[$];

  always @(negedge clk) begin
    if (press_pulse === 1'b1) begin
      pulse_cnt++;
      last_pulse = cyc;
      pulse_log.push_back(cyc);
      if (prev_pulse === 1'b1) wide_pulses++;
    end
    prev_pulse = press_pulse;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n edges; returns 1 time unit after the last edge.
  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Move past the following negedge so the monitor has seen the last edge.
  task automatic settle();
    #6;
  endtask

  task automatic do_reset();
    rst_btn = 1'b0;
    tick(2);
    rst_btn = 1'b1;
    tick(2);
  endtask

  typedef struct packed {
    logic       btn;
    logic [7:0] cycles;
    logic [3:0] pulses;
    logic [3:0] led;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int unsigned t0;
  int unsigned pc0;
  int unsigned exp_off[$];

  initial begin
    vecs[0]  = '{btn: 1'b1, cycles: 8'd5,  pulses: 4'd0, led: 4'd0}; // idle
    vecs[1]  = '{btn: 1'b0, cycles: 8'd25, pulses: 4'd1, led: 4'd1}; // clean press
    vecs[2]  = '{btn: 1'b1, cycles: 8'd20, pulses: 4'd0, led: 4'd1}; // clean release
    vecs[3]  = '{btn: 1'b0, cycles: 8'd5,  pulses: 4'd0, led: 4'd1}; // bounce low
    vecs[4]  = '{btn: 1'b1, cycles: 8'd2,  pulses: 4'd0, led: 4'd1}; // bounce high
    vecs[5]  = '{btn: 1'b0, cycles: 8'd25, pulses: 4'd1, led: 4'd2}; // settled press
    vecs[6]  = '{btn: 1'b1, cycles: 8'd3,  pulses: 4'd0, led: 4'd2}; // release chatter
    vecs[7]  = '{btn: 1'b0, cycles: 8'd3,  pulses: 4'd0, led: 4'd2};
    vecs[8]  = '{btn: 1'b1, cycles: 8'd20, pulses: 4'd0, led: 4'd2};
    vecs[9]  = '{btn: 1'b0, cycles: 8'd10, pulses: 4'd0, led: 4'd2}; // one short of debounce
    vecs[10] = '{btn: 1'b1, cycles: 8'd20, pulses: 4'd0, led: 4'd2};
    vecs[11] = '{btn: 1'b0, cycles: 8'd11, pulses: 4'd0, led: 4'd2}; // exactly enough
    vecs[12] = '{btn: 1'b1, cycles: 8'd20, pulses: 4'd1, led: 4'd3}; // its pulse lands here

    // Reset state
    inc_btn = 1'b1;
    rst_btn = 1'b0;
    tick(3);
    settle();
    check("reset_led",   32'(led),         32'd0);
    check("reset_pulse", 32'(press_pulse), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    rst_btn = 1'b1;
    tick(2);

    // Table-driven segments
    for (int i = 0; i < NVEC; i++) begin
      pc0 = pulse_cnt;
      inc_btn = vecs[i].btn;
      tick(32'(vecs[i].cycles));
      settle();
      check($sformatf("vec%0d_pulses", i), pulse_cnt - pc0, 32'(vecs[i].pulses));
      check($sformatf("vec%0d_led", i),    32'(led),        32'(vecs[i].led));
    end

    // Latency of a clean press: pulse 13 edges after the first low sample edge
    pc0 = pulse_cnt;
    t0 = cyc;
    inc_btn = 1'b0;
    tick(25);
    settle();
    check("latency_pulses", pulse_cnt - pc0, 32'd1);
    check("latency_edges",  last_pulse - t0, 32'd13);
    check("latency_led",    32'(led),        32'd4);
    inc_btn = 1'b1;
    tick(20);

    // Reset in the middle of PRESS_WAIT with the button still held
    t0 = cyc;
    inc_btn = 1'b0;
    tick(8);
    check("midrst_timer", 32'(dut.timer_q), 32'd5);
    pc0 = pulse_cnt;
    rst_btn = 1'b0;
    #1;
    check("midrst_led",   32'(led),         32'd0);
    check("midrst_pulse", 32'(press_pulse), 32'd0);
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    tick(2);
    rst_btn = 1'b1;
    t0 = cyc;
    tick(25);
    settle();
    check("midrst_after_pulses", pulse_cnt - pc0, 32'd1);
    check("midrst_after_edges",  last_pulse - t0, 32'd13);
    check("midrst_after_led",    32'(led),        32'd1);
    inc_btn = 1'b1;
    tick(20);

    // Wrap: 16 presses from led=0
    do_reset();
    pc0 = pulse_cnt;
    for (int p = 0; p < 16; p++) begin
      inc_btn = 1'b0;
      tick(15);
      inc_btn = 1'b1;
      tick(15);
    end
    settle();
    check("wrap_pulses", pulse_cnt - pc0, 32'd16);
    check("wrap_led",    32'(led),        32'd0);

    // Long hold: auto-repeat behaviour depends on the build
`ifdef BTN_AUTOREPEAT_EN
    exp_off = '{13, 33, 53, 73, 93};
`else
    exp_off = '{13};
`endif
    pulse_log.delete();
    t0 = cyc;
    inc_btn = 1'b0;
    tick(100);
    inc_btn = 1'b1;
    tick(20);
    settle();
    check("hold_pulses", pulse_log.size(), exp_off.size());
    for (int k = 0; k < exp_off.size() && k < pulse_log.size(); k++)
      check($sformatf("hold_off%0d", k), pulse_log[k] - t0, exp_off[k]);
    check("hold_led", 32'(led), exp_off.size());

    check("pulse_width_one", wide_pulses, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
